// File: rtl/if_id_pkg.sv
// -----------------------------------------------------------------------------
// if_id_pkg
// Shared definitions for the IF/ID pipeline buffer and the decode-stage logic.
//   - Opcode constants of the immediate instructions that take a zero-extended
//     immediate (ANDI, ORI, XORI, LUI).
//   - Extend-control encodings (SE_SIGN / SE_ZERO) as consumed by Sign_Extend.
//   - Packed entry struct stored in each buffer slot.
// -----------------------------------------------------------------------------
package if_id_pkg;

  localparam int IF_ID_DATA_W = 32;
  localparam int OPC_W        = 6;

  localparam logic [OPC_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LUI  = 6'h0F;

  localparam logic SE_SIGN = 1'b0;
  localparam logic SE_ZERO = 1'b1;

  typedef struct packed {
    logic [IF_ID_DATA_W-1:0] instr;
    logic [IF_ID_DATA_W-1:0] pc_plus4;
    logic                    se_ctrl;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_entry_dec.sv
// -----------------------------------------------------------------------------
// if_id_entry_dec
// Combinational opcode -> extend-control decode.
// Ports:
//   opcode_i   in  6  instr[31:26]
//   se_ctrl_o  out 1  SE_ZERO for ANDI/ORI/XORI/LUI, SE_SIGN otherwise
// -----------------------------------------------------------------------------
module if_id_entry_dec
  import if_id_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output logic             se_ctrl_o
);

  always_comb begin
    se_ctrl_o = SE_SIGN;
    case (opcode_i)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: se_ctrl_o = SE_ZERO;
      default:                          se_ctrl_o = SE_SIGN;
    endcase
  end

endmodule

// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
// Two-entry elastic register between instruction fetch and decode. The main
// register is the head entry and drives every data output; the skid register
// catches the one instruction fetch may still deliver after decode stalls.
// Optional feature macro: IF_ID_BUFFER_STAT_EN (adds stall_cnt_o).
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       synchronous active-high reset
//   flush_i      in   1       drop all buffered entries
//   valid_i      in   1       fetch presents an instruction
//   ready_o      out  1       buffer accepts this cycle (registered)
//   instr_i      in   DATA_W  fetched instruction
//   pc_plus4_i   in   DATA_W  PC+4 of fetched instruction
//   valid_o      out  1       head entry valid (registered)
//   ready_i      in   1       decode consumes head entry
//   instr_o      out  DATA_W  head instruction
//   pc_plus4_o   out  DATA_W  head PC+4
//   imm16_o      out  IMM_W   head instr[IMM_W-1:0] -> Sign_Extend data_i
//   se_ctrl_o    out  1       1 = zero-extend, 0 = sign-extend -> SECtrl_i
//   stall_cnt_o  out  16      (macro only) saturating count of stalled cycles
// DATA_W must match the entry width held in if_id_pkg.
// -----------------------------------------------------------------------------
module if_id_buffer
  import if_id_pkg::*;
#(
  parameter int DATA_W = IF_ID_DATA_W,
  parameter int IMM_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [IMM_W-1:0]  imm16_o,
  output logic              se_ctrl_o
`ifdef IF_ID_BUFFER_STAT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  if_id_entry_t main_q, main_d;
  if_id_entry_t skid_q, skid_d;
  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;

  logic         new_se_ctrl;
  if_id_entry_t new_entry;
  logic         push;
  logic         pop;

  // extend control is decided once, at write time, and travels with the entry
  if_id_entry_dec u_dec (
    .opcode_i  (instr_i[DATA_W-1 -: OPC_W]),
    .se_ctrl_o (new_se_ctrl)
  );

  always_comb begin
    new_entry.instr    = instr_i;
    new_entry.pc_plus4 = pc_plus4_i;
    new_entry.se_ctrl  = new_se_ctrl;
  end

  // ready depends only on registered state, never on ready_i
  assign ready_o = !skid_valid_q;
  assign valid_o = main_valid_q;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      // data registers keep their contents; only occupancy is cleared
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (push) begin
            main_d       = new_entry;
            main_valid_d = 1'b1;
          end
        end
        2'b10: begin
          if (push && pop) begin
            main_d = new_entry;
          end else if (push) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
          end else if (pop) begin
            main_valid_d = 1'b0;
          end
        end
        2'b11: begin
          // push cannot happen here: ready_o is low while skid is occupied
          if (pop) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // skid without main is unreachable; recover to empty
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign instr_o    = main_q.instr;
  assign pc_plus4_o = main_q.pc_plus4;
  assign imm16_o    = main_q.instr[IMM_W-1:0];
  assign se_ctrl_o  = main_q.se_ctrl;

`ifdef IF_ID_BUFFER_STAT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_o && !ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // flush deliberately does not clear the statistic
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_id_buffer
// Directed, table-driven bench for if_id_buffer. Each row drives inputs for
// one rising edge and lists the outputs expected just after that edge.
// -----------------------------------------------------------------------------
module tb_if_id_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic        ready_o, valid_o, se_ctrl_o;
  logic [31:0] instr_i, pc_plus4_i, instr_o, pc_plus4_o;
  logic [15:0] imm16_o;
`ifdef IF_ID_BUFFER_STAT_EN
  logic [15:0] stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  if_id_buffer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .instr_i    (instr_i),
    .pc_plus4_i (pc_plus4_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .instr_o    (instr_o),
    .pc_plus4_o (pc_plus4_o),
    .imm16_o    (imm16_o),
    .se_ctrl_o  (se_ctrl_o)
`ifdef IF_ID_BUFFER_STAT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_se;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic rst, logic flush, logic valid,
                              logic [31:0] instr, logic [31:0] pc, logic ready,
                              logic ev, logic er, logic [31:0] ei,
                              logic [31:0] ep, logic es);
    vec_t v;
    v.rst = rst; v.flush = flush; v.valid = valid; v.instr = instr;
    v.pc = pc; v.ready = ready; v.exp_valid = ev; v.exp_ready = er;
    v.exp_instr = ei; v.exp_pc = ep; v.exp_se = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic flush, input logic valid,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic ready);
    rst_i = rst; flush_i = flush; valid_i = valid;
    instr_i = instr; pc_plus4_i = pc; ready_i = ready;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] exp_imm;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    //                  rst   fl    vld   instr          pc      rdy   ev    er    exp instr      exp pc  se
    vecs[0]  = mk(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h44, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0,  1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h44, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0,  1'b0);
    // single pass-through (ORI)
    vecs[2]  = mk(1'b0, 1'b0, 1'b1, 32'h3402_8001, 32'h04, 1'b1, 1'b1, 1'b1, 32'h3402_8001, 32'h04, 1'b1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 1'b1, 32'h3402_8001, 32'h04, 1'b1);
    // stall and fill, then drain in order
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 32'h2002_FFFF, 32'h08, 1'b0, 1'b1, 1'b1, 32'h2002_FFFF, 32'h08, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 32'h3403_0010, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h2002_FFFF, 32'h08, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h50, 1'b0, 1'b1, 1'b0, 32'h2002_FFFF, 32'h08, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b1, 1'b1, 32'h3403_0010, 32'h0C, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 1'b1, 32'h3403_0010, 32'h0C, 1'b1);
    // fill to two (ANDI head), then flush with fetch presenting
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'h3004_00AA, 32'h10, 1'b0, 1'b1, 1'b1, 32'h3004_00AA, 32'h10, 1'b1);
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 32'h2005_1234, 32'h14, 1'b0, 1'b1, 1'b0, 32'h3004_00AA, 32'h10, 1'b1);
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 32'h3C06_5555, 32'h18, 1'b1, 1'b0, 1'b1, 32'h3004_00AA, 32'h10, 1'b1);
    // LUI head, then flush overrides a real push (XORI dropped)
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 32'h3C06_5555, 32'h18, 1'b0, 1'b1, 1'b1, 32'h3C06_5555, 32'h18, 1'b1);
    vecs[13] = mk(1'b0, 1'b1, 1'b1, 32'h3807_7777, 32'h1C, 1'b0, 1'b0, 1'b1, 32'h3C06_5555, 32'h18, 1'b1);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 1'b1, 32'h3C06_5555, 32'h18, 1'b1);
    // reset mid-operation beats flush and push
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h2008_0001, 32'h20, 1'b0, 1'b1, 1'b1, 32'h2008_0001, 32'h20, 1'b0);
    vecs[16] = mk(1'b1, 1'b1, 1'b1, 32'h3409_0009, 32'h24, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0,  1'b0);
    // count 1 push+pop overwrites head
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 32'h3409_0002, 32'h24, 1'b1, 1'b1, 1'b1, 32'h3409_0002, 32'h24, 1'b1);
    vecs[18] = mk(1'b0, 1'b0, 1'b1, 32'h200A_0003, 32'h28, 1'b1, 1'b1, 1'b1, 32'h200A_0003, 32'h28, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 1'b1, 32'h200A_0003, 32'h28, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].valid, vecs[i].instr,
            vecs[i].pc, vecs[i].ready);
      tick();
      exp_imm = {16'h0, vecs[i].exp_instr[15:0]};
      $display("vec %0d: valid_o=%0b ready_o=%0b instr_o=%08h pc_o=%08h imm=%04h se=%0b",
               i, valid_o, ready_o, instr_o, pc_plus4_o, imm16_o, se_ctrl_o);
      check($sformatf("v%0d valid_o", i), {31'h0, valid_o}, {31'h0, vecs[i].exp_valid});
      check($sformatf("v%0d ready_o", i), {31'h0, ready_o}, {31'h0, vecs[i].exp_ready});
      check($sformatf("v%0d instr_o", i), instr_o, vecs[i].exp_instr);
      check($sformatf("v%0d pc_plus4_o", i), pc_plus4_o, vecs[i].exp_pc);
      check($sformatf("v%0d imm16_o", i), {16'h0, imm16_o}, exp_imm);
      check($sformatf("v%0d se_ctrl_o", i), {31'h0, se_ctrl_o}, {31'h0, vecs[i].exp_se});
    end

    // back-to-back streaming: each pushed entry is head right after its push
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b1, {6'h0D, 10'h0, 16'(k)}, 32'h100 + 32'(4 * k), 1'b1);
      tick();
      $display("stream %0d: valid_o=%0b ready_o=%0b pc_o=%08h imm=%04h",
               k, valid_o, ready_o, pc_plus4_o, imm16_o);
      check($sformatf("s%0d valid_o", k), {31'h0, valid_o}, 32'h1);
      check($sformatf("s%0d ready_o", k), {31'h0, ready_o}, 32'h1);
      check($sformatf("s%0d pc_plus4_o", k), pc_plus4_o, 32'h100 + 32'(4 * k));
      check($sformatf("s%0d imm16_o", k), {16'h0, imm16_o}, 32'(k));
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    $display("stream drain: valid_o=%0b ready_o=%0b", valid_o, ready_o);
    check("stream drain valid_o", {31'h0, valid_o}, 32'h0);

`ifdef IF_ID_BUFFER_STAT_EN
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("stat reset", {16'h0, stall_cnt_o}, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h2002_0001, 32'h200, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    $display("stat: stall_cnt_o=%0d after 5 stalled cycles", stall_cnt_o);
    check("stat 5 stalls", {16'h0, stall_cnt_o}, 32'd5);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    $display("stat: stall_cnt_o=%0d after flush", stall_cnt_o);
    check("stat after flush", {16'h0, stall_cnt_o}, 32'd5);
    check("stat flush valid_o", {31'h0, valid_o}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Two-entry elastic pipeline register between instruction fetch and decode.
- Holds the fetched instruction and PC+4, and presents the 16-bit immediate field with a pre-decoded extend-control bit.
- These feed the Sign_Extend stage (data_i, SECtrl_i) directly downstream.
- Valid/ready handshakes on both sides let fetch keep running for one cycle after decode stalls without losing an instruction.

Parameters:
- DATA_W, 32, instruction and PC width
- IMM_W, 16, immediate field width; always instr[IMM_W-1:0]

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  synchronous flush of all buffered entries (branch/jump taken)
- valid_i  in  1  fetch presents an instruction
- ready_o  out  1  buffer can accept this cycle
- instr_i  in  DATA_W  fetched instruction
- pc_plus4_i  in  DATA_W  PC+4 of the fetched instruction
- valid_o  out  1  head entry valid toward decode
- ready_i  in  1  decode consumes the head entry this cycle
- instr_o  out  DATA_W  head instruction
- pc_plus4_o  out  DATA_W  head PC+4
- imm16_o  out  IMM_W  head instr[15:0]; connects to Sign_Extend data_i
- se_ctrl_o  out  1  1 = zero-extend, 0 = sign-extend; connects to Sign_Extend SECtrl_i

Behaviour:
- Storage:
  - Main register = head entry, driving all *_o data outputs.
  - Skid register = second entry.
  - Occupancy count 0..2.
- Handshakes:
  - push = valid_i & ready_o
  - pop = valid_o & ready_i
- Outputs:
  - ready_o = !skid_valid, registered. No combinational path from ready_i.
  - valid_o = main_valid, registered.
- Transitions:
  - count 0, push: write main; count becomes 1.
  - count 1, push and pop together: overwrite main with the new entry; count stays 1.
  - count 1, push only: write skid; count becomes 2, so ready_o drops next cycle.
  - count 1, pop only: count becomes 0.
  - count 2, pop: main takes skid contents; count becomes 1. valid_i is ignored because ready_o = 0.
  - count 2, no pop: hold all state; outputs stable.
- se_ctrl:
  - Computed when an entry is written and stored with it.
  - 1 when instr[31:26] is 6'h0C (ANDI), 6'h0D (ORI), 6'h0E (XORI) or 6'h0F (LUI); 0 otherwise.
- Latency: one cycle from push into an empty buffer to valid_o = 1. No bypass path.
- Data outputs when valid_o = 0 hold their last value and are don't-care for the consumer.
- Flush:
  - Next cycle: main_valid = 0, skid_valid = 0, ready_o = 1.
  - Overrides a simultaneous push; the pushed instruction is dropped.
  - Overrides a simultaneous pop; the pop is harmless.
- Reset:
  - Next edge: valid_o = 0, ready_o = 1, instr_o = 0, pc_plus4_o = 0, imm16_o = 0, se_ctrl_o = 0, count = 0.
  - Takes priority over flush and handshakes.
  - Mid-operation, reset discards both entries.
- No overflow: a push is impossible at count 2.
- No underflow: pop requires valid_o.

Optional Feature:
- Macro: IF_ID_BUFFER_STAT_EN
- Defined:
  - Adds output stall_cnt_o [15:0], counting cycles with valid_o & !ready_i.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i only; flush does not clear it.
- Not defined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package if_id_pkg holds:
  - opcode constants OP_ANDI, OP_ORI, OP_XORI, OP_LUI
  - SE_SIGN = 1'b0, SE_ZERO = 1'b1
  - packed entry struct {instr, pc_plus4, se_ctrl}
- One sub-module, if_id_entry_dec: combinational opcode-to-se_ctrl decode, reused by decode-stage checks.
- The buffer itself stays a single module.

Test Plan:
- Reset: assert rst_i for 2 cycles with valid_i = 1 → valid_o = 0, ready_o = 1, all data outputs 0.
- Single pass-through: push instr 32'h3402_8001 (ORI), pc_plus4 32'h0000_0004, ready_i = 1 → next cycle valid_o = 1, imm16_o = 16'h8001, se_ctrl_o = 1.
- Stall and fill: ready_i = 0; push ADDI 32'h2002_FFFF then 32'h3403_0010 → ready_o = 0 after the second push. Release ready_i → heads in order: imm16 16'hFFFF with se_ctrl 0, then 16'h0010 with se_ctrl 1.
- Back-to-back streaming: ready_i = 1 and valid_i = 1 for 10 cycles with incrementing pc_plus4 → 10 pops in order, count never exceeds 1, ready_o stays 1.
- Flush with full buffer and simultaneous push → next cycle valid_o = 0, ready_o = 1; the pushed instruction never appears.
- With IF_ID_BUFFER_STAT_EN: hold valid_o = 1, ready_i = 0 for 5 cycles → stall_cnt_o = 5. Flush → stall_cnt_o still 5.
